// File: rtl/wb_trace_buf.sv
// Retirement trace buffer fed by the write-back stage.
// Captures retired PC/instruction/result with a retire sequence tag into a
// circular buffer, started immediately or on a PC trigger, and either stops
// or overwrites the oldest entry when full. Entries drain through a
// first-word-fall-through valid/ready port.

`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module wb_trace_buf #(
    parameter int ADDR_W = `SIZE_ADDR,
    parameter int DATA_W = `SIZE_DATA,
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 16
) (
    input  logic                       iw_clk,
    input  logic                       iw_rst,
    input  logic                       iw_arm,
    input  logic                       iw_disarm,
    input  logic                       iw_trig_en,
    input  logic [ADDR_W-1:0]          iw_trig_pc,
    input  logic                       iw_stop_on_full,
    input  logic                       iw_ret_valid,
    input  logic [ADDR_W-1:0]          iw_ret_pc,
    input  logic [DATA_W-1:0]          iw_ret_instr,
    input  logic [DATA_W-1:0]          iw_ret_result,
    output logic                       ow_rd_valid,
    input  logic                       iw_rd_ready,
    output logic [ADDR_W-1:0]          ow_rd_pc,
    output logic [DATA_W-1:0]          ow_rd_instr,
    output logic [DATA_W-1:0]          ow_rd_result,
    output logic [SEQ_W-1:0]           ow_rd_seq,
    output logic [1:0]                 ow_state,
    output logic [$clog2(DEPTH):0]     ow_count,
    output logic [15:0]                ow_dropped
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        STOPPED = 2'd3
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [CNT_W-1:0]   count;
    logic [SEQ_W-1:0]   seq;
    logic [15:0]        dropped;

    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [DATA_W-1:0]  instr_mem [DEPTH];
    logic [DATA_W-1:0]  res_mem   [DEPTH];
    logic [SEQ_W-1:0]   seq_mem   [DEPTH];

    logic capture;
    logic pop;
    logic full;
    logic do_write;
    logic overwrite;
    logic stop_now;
    logic drop;

    // Decode this cycle's capture, pop, write and drop events; arm and
    // disarm both suppress capture so the arming cycle never records.
    always_comb begin
        capture   = 1'b0;
        if (!iw_arm && !iw_disarm && iw_ret_valid) begin
            capture = (state == CAPTURE) ||
                      ((state == ARMED) && (iw_ret_pc == iw_trig_pc));
        end
        pop       = (count != '0) && iw_rd_ready;
        full      = (count == CNT_W'(DEPTH));
        // A pop on a full buffer frees a slot, so it is never a drop.
        stop_now  = capture && full && !pop && iw_stop_on_full;
        overwrite = capture && full && !pop && !iw_stop_on_full;
        do_write  = capture && !stop_now;
        drop      = (capture && full && !pop) ||
                    (!iw_arm && !iw_disarm && (state == STOPPED) && iw_ret_valid);
    end

    // Entry storage; contents are don't-care until counted as valid.
    always_ff @(posedge iw_clk) begin
        if (do_write) begin
            pc_mem[wptr]    <= iw_ret_pc;
            instr_mem[wptr] <= iw_ret_instr;
            res_mem[wptr]   <= iw_ret_result;
            seq_mem[wptr]   <= seq;
        end
    end

    // Control: state machine, pointers, occupancy, sequence tag, drop count.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state   <= IDLE;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            seq     <= '0;
            dropped <= '0;
        end else begin
            seq <= seq + SEQ_W'(iw_ret_valid);
            if (iw_arm) begin
                state   <= iw_trig_en ? ARMED : CAPTURE;
                wptr    <= '0;
                rptr    <= '0;
                count   <= '0;
                dropped <= '0;
            end else begin
                if (iw_disarm) begin
                    state <= IDLE;
                end else if ((state == ARMED) && capture) begin
                    state <= CAPTURE;
                end else if (stop_now) begin
                    state <= STOPPED;
                end
                if (do_write) begin
                    wptr <= wptr + PTR_W'(1);
                end
                if (pop || overwrite) begin
                    rptr <= rptr + PTR_W'(1);
                end
                if (do_write && !pop && !overwrite) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !do_write) begin
                    count <= count - CNT_W'(1);
                end
                if (drop && (dropped != 16'hFFFF)) begin
                    dropped <= dropped + 16'd1;
                end
            end
        end
    end

    // Head entry is shown combinationally; fields read as zero when empty.
    always_comb begin
        ow_rd_valid  = (count != '0);
        ow_rd_pc     = ow_rd_valid ? pc_mem[rptr]    : '0;
        ow_rd_instr  = ow_rd_valid ? instr_mem[rptr] : '0;
        ow_rd_result = ow_rd_valid ? res_mem[rptr]   : '0;
        ow_rd_seq    = ow_rd_valid ? seq_mem[rptr]   : '0;
        ow_state     = state;
        ow_count     = count;
        ow_dropped   = dropped;
    end

endmodule

// File: doc/wb_trace_buf.md
Name: wb_trace_buf

Overview:
- Retirement trace buffer downstream of the write-back stage.
- Consumes the per-cycle retired PC, instruction and result from the core's WB outputs and stores them as tagged entries in a circular buffer.
- Capture can start immediately or on a PC trigger, and can either stop or overwrite the oldest entry when full.
- A debug host drains entries through a first-word-fall-through valid/ready read port.

Parameters:
- ADDR_W, `SIZE_ADDR: PC width.
- DATA_W, `SIZE_DATA: instruction and result width.
- DEPTH, 16: number of entries. Power of two, minimum 2.
- SEQ_W, 16: width of the retire sequence tag.

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  reset
- iw_arm  in  1  one-cycle pulse: flush buffer, zero drop counter, enter ARMED or CAPTURE
- iw_disarm  in  1  one-cycle pulse: return to IDLE, keep buffer contents
- iw_trig_en  in  1  1 = wait for PC match before capturing; 0 = capture immediately on arm
- iw_trig_pc  in  ADDR_W  trigger PC
- iw_stop_on_full  in  1  1 = stop when full; 0 = overwrite oldest entry
- iw_ret_valid  in  1  an instruction retires this cycle
- iw_ret_pc  in  ADDR_W  retired PC
- iw_ret_instr  in  DATA_W  retired instruction
- iw_ret_result  in  DATA_W  retired result
- ow_rd_valid  out  1  head entry available
- iw_rd_ready  in  1  consumer accepts head entry
- ow_rd_pc  out  ADDR_W  head PC
- ow_rd_instr  out  DATA_W  head instruction
- ow_rd_result  out  DATA_W  head result
- ow_rd_seq  out  SEQ_W  head sequence tag
- ow_state  out  2  0=IDLE, 1=ARMED, 2=CAPTURE, 3=STOPPED
- ow_count  out  log2(DEPTH)+1  number of valid entries
- ow_dropped  out  16  retirements lost, saturates at 16'hFFFF

Behaviour:
- Reset is asynchronous and active-high on iw_rst; the clock is iw_clk. On reset: state IDLE, pointers 0, count 0, sequence counter 0, ow_dropped 0, ow_rd_valid 0. All other outputs reset to 0.
- Sequence counter:
  - Increments by 1 on every iw_ret_valid, in every state. Wraps mod 2^SEQ_W.
  - A captured entry stores the counter value before that cycle's increment.
- State machine:
  - IDLE: iw_arm goes to ARMED if iw_trig_en=1, else to CAPTURE.
  - ARMED: when iw_ret_valid and iw_ret_pc == iw_trig_pc, go to CAPTURE. The triggering instruction itself is captured in that same cycle.
  - CAPTURE: every iw_ret_valid writes one entry.
  - STOPPED: no writes.
  - iw_arm in any state restarts arming: buffer flushed and ow_dropped cleared on the next clock edge. Retirements in the arming cycle are not captured.
  - iw_disarm in any state goes to IDLE. iw_arm has priority over iw_disarm.
- Write when count < DEPTH: store at the write pointer, advance the write pointer, count+1.
- Write when full:
  - iw_stop_on_full=1: entry discarded, ow_dropped+1, state goes to STOPPED.
  - iw_stop_on_full=0: oldest entry overwritten, read and write pointers both advance, count stays DEPTH, ow_dropped+1.
- Read port:
  - ow_rd_valid = (count != 0). The ow_rd_* fields show the head entry combinationally from storage.
  - Pop on ow_rd_valid & iw_rd_ready: the read pointer advances.
  - Pops are legal in every state, including IDLE and STOPPED.
- Simultaneous pop and write:
  - Pointers both advance, count unchanged.
  - When full, this case is not a drop and does not stop capture.
  - When empty, the write wins and there is no pop, since ow_rd_valid=0.
- Pointers wrap mod DEPTH. Count never exceeds DEPTH and never underflows.
- Latency: a retirement captured at edge N is visible on ow_rd_* after edge N when count was 0.

Test Plan:
- Reset mid-capture with 3 entries stored -> count=0, state=0, dropped=0, ow_rd_valid=0 immediately (asynchronous), seq restarts at 0.
- DEPTH=4, trig_en=0, arm, retire PCs 10,11,12, then drain with ready=1 -> reads PCs 10,11,12 with seq 0,1,2; count goes 3→0.
- trig_en=1, trig_pc=0x20, retire 0x1E,0x1F,0x20,0x21 -> state ARMED→CAPTURE on 0x20; buffer holds 0x20,0x21 with seq 2,3.
- DEPTH=4, stop_on_full=1, 6 retirements with no reads -> count=4, dropped=2, state=3; entries seq 0–3; a pop leaves state STOPPED.
- DEPTH=4, stop_on_full=0, 6 retirements -> count=4, dropped=2, head seq=2, tail seq=5.
- Full buffer, pop and retire in the same cycle -> count stays 4, dropped unchanged, new entry is at the tail; re-arm -> count=0, dropped=0, seq not cleared.
